fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_if.sv | 44 ++++
 rtl/fifo_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Requester, FIFO write-port and status signals shared by the write-side arbiter.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic [ADDR_WIDTH:0]           fifo_used;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  fifo_full,
    input  fifo_used,
    output req_ready,
    output fifo_wr_en,
    output fifo_wr_data,
    output grant,
    output busy
  );

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output fifo_full,
    output fifo_used,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  grant,
    input  busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// A burst is admitted only when the lagging fill count guarantees room for MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              srst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW1 = PtrW + 1;
  localparam int unsigned CntW  = $clog2(MAX_BURST + 1);
  localparam int unsigned FreeW = ADDR_WIDTH + 2;

  localparam logic [FreeW-1:0] Depth     = FreeW'(2 ** ADDR_WIDTH);
  localparam logic [FreeW-1:0] BurstRoom = FreeW'(MAX_BURST);
  localparam logic [CntW-1:0]  BurstLast = CntW'(MAX_BURST);
  localparam logic [PtrW:0]    NumReqW   = PtrW1'(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;

  logic [FreeW-1:0]      free;
  logic                  sel_found;
  logic [PtrW-1:0]       sel_idx;
  logic [PtrW:0]         cand;
  logic [PtrW-1:0]       owner_idx;
  logic [PtrW:0]         owner_inc;
  logic [PtrW-1:0]       next_ptr;
  logic                  owner_valid;
  logic                  owner_last;
  logic [CntW-1:0]       beat_inc;
  logic                  burst_end;
  logic                  xfer_live;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] wr_data;

  assign free = Depth - {1'b0, bus.fifo_used};

  // First valid requester scanning from rr_ptr upward, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + PtrW1'(k);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!sel_found && bus.req_valid[cand[PtrW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = PtrW'(i);
      end
    end
  end

  assign owner_inc   = {1'b0, owner_idx} + PtrW1'(1);
  assign next_ptr    = (owner_inc >= NumReqW) ? '0 : owner_inc[PtrW-1:0];
  assign owner_valid = |(bus.req_valid & grant_q);
  assign owner_last  = |(bus.req_last & grant_q);
  assign beat_inc    = beat_cnt_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    burst_end  = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (sel_found && (free >= BurstRoom)) begin
          grant_d    = NUM_REQ'(1) << sel_idx;
          beat_cnt_d = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        // A full FIFO freezes the burst: no beat, no release.
        if (!bus.fifo_full) begin
          if (owner_valid) begin
            beat_cnt_d = beat_inc;
            burst_end  = owner_last || (beat_inc == BurstLast);
          end else begin
            burst_end  = 1'b1;
          end
          if (burst_end) begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Handshake is masked while reset is asserted so a word in the reset cycle is never written.
  assign xfer_live = (state_q == StXfer) && srst_n;
  assign ready     = xfer_live ? (grant_q & {NUM_REQ{~bus.fifo_full}}) : '0;

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        wr_data = wr_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = |(bus.req_valid & ready);
  assign bus.fifo_wr_data = wr_data;
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == StXfer);

`ifndef SYNTHESIS
  a_wr_en_safe: assert property (@(posedge clk) disable iff (!srst_n)
    bus.fifo_wr_en |-> ((|grant_q) && !bus.fifo_full));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!srst_n)
    $onehot0(grant_q));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester sources, a write-pointer model and a
// scoreboard queue of expected FIFO words checked by an independent write monitor.
module tb_fifo_wr_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned MAX_BURST  = 4;
  localparam int          DEPTH      = 16;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  logic [7:0]          seq [NUM_REQ];
  int                  limit [NUM_REQ];
  int                  last_at [NUM_REQ];
  logic [NUM_REQ-1:0]  en = '0;
  logic [ADDR_WIDTH:0] used;
  logic                full_r;
  logic                force_full = 1'b0;
  logic                model_clr = 1'b1;
  logic [7:0]          exp_q [$];
  logic [7:0]          mon_exp;
  int                  checks = 0;
  int                  errors = 0;

  // Requester i sends words i*16+seq; valid until 'limit' words, last on word 'last_at'.
  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = en[i] && (int'(seq[i]) < limit[i]);
      bus.req_last[i]  = (int'(seq[i]) == last_at[i]);
      bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'(i * 16) + seq[i];
    end
  end

  assign bus.fifo_full = full_r | force_full;
  assign bus.fifo_used = used;

  // Write-pointer controller model: registered count and full, no reads.
  always @(posedge clk) begin
    if (model_clr) begin
      used   <= '0;
      full_r <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) seq[i] <= 8'd0;
    end else begin
      if (bus.fifo_wr_en) begin
        used   <= used + 1'b1;
        full_r <= (int'(used) + 1 == DEPTH);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) seq[i] <= seq[i] + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_data: actual=%h required=<no write>", bus.fifo_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.fifo_wr_data !== mon_exp || bus.fifo_full !== 1'b0 || bus.grant == '0) begin
          errors++;
          $display("FAIL wr_data: actual=%h full=%b grant=%b required=%h full=0 grant!=0",
                   bus.fifo_wr_data, bus.fifo_full, bus.grant, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic step();
    next_cycle();
    sample();
  endtask

  task automatic clear_stim();
    en         = '0;
    force_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      limit[i]   = 255;
      last_at[i] = -1;
    end
  endtask

  // Holds reset for n checked cycles, then releases; returns sampling the first IDLE cycle.
  task automatic do_reset(input int n);
    srst_n    = 1'b0;
    model_clr = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
    end
    next_cycle();
    srst_n    = 1'b1;
    model_clr = 1'b0;
    sample();
  endtask

  initial begin
    logic [3:0] eg;

    // Reset then fairness/fill: four 4-word bursts, one dead cycle between each.
    clear_stim();
    en = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 4; w++) exp_q.push_back(8'(r * 16 + w));
    end
    do_reset(3);
    chk("t1_idle_grant", 32'(bus.grant), 32'd0);
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);
    for (int c = 1; c <= 27; c++) begin
      step();
      if (c <= 19 && ((c - 1) % 5) < 4) eg = 4'(1 << ((c - 1) / 5));
      else eg = 4'd0;
      chk($sformatf("t2_grant_c%0d", c), 32'(bus.grant), 32'(eg));
      chk($sformatf("t2_busy_c%0d", c), 32'(bus.busy), 32'(eg != 4'd0));
      chk($sformatf("t2_wr_en_c%0d", c), 32'(bus.fifo_wr_en), 32'(eg != 4'd0));
      if (c == 15) chk("t2_used_at_admit", 32'(bus.fifo_used), 32'd12);
    end
    chk("t2_used_final", 32'(bus.fifo_used), 32'd16);
    chk("t2_full_final", 32'(bus.fifo_full), 32'd1);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Early end on req_last, then rr_ptr moves past the owner to req2.
    next_cycle();
    clear_stim();
    en = 4'b0110;
    limit[1] = 2;
    limit[2] = 4;
    last_at[1] = 1;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    for (int w = 0; w < 4; w++) exp_q.push_back(8'(8'h20 + w));
    do_reset(1);
    step(); chk("t3_grant_c1", 32'(bus.grant), 32'h2);
    step(); chk("t3_grant_c2", 32'(bus.grant), 32'h2);
    step(); chk("t3_grant_c3", 32'(bus.grant), 32'h0);
    chk("t3_busy_c3", 32'(bus.busy), 32'd0);
    step(); chk("t3_grant_c4", 32'(bus.grant), 32'h4);
    repeat (8) step();
    chk("t3_grant_end", 32'(bus.grant), 32'h0);
    chk("t3_used", 32'(bus.fifo_used), 32'd6);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Full stall after the first beat; grant held, remaining three beats follow.
    next_cycle();
    clear_stim();
    en = 4'b0001;
    limit[0] = 4;
    for (int w = 0; w < 4; w++) exp_q.push_back(8'(w));
    do_reset(1);
    step();
    chk("t4_grant_c1", 32'(bus.grant), 32'h1);
    chk("t4_wr_en_c1", 32'(bus.fifo_wr_en), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      force_full = 1'b1;
      sample();
      chk($sformatf("t4_ready_c%0d", c), 32'(bus.req_ready), 32'h0);
      chk($sformatf("t4_wr_en_c%0d", c), 32'(bus.fifo_wr_en), 32'd0);
      chk($sformatf("t4_grant_c%0d", c), 32'(bus.grant), 32'h1);
    end
    next_cycle();
    force_full = 1'b0;
    sample();
    chk("t4_wr_en_c5", 32'(bus.fifo_wr_en), 32'd1);
    step();
    step();
    step();
    chk("t4_grant_c8", 32'(bus.grant), 32'h0);
    chk("t4_used", 32'(bus.fifo_used), 32'd4);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Valid drop releases the grant; next grant req3, then wrap to req0, then req1.
    next_cycle();
    clear_stim();
    en = 4'b0100;
    limit[2] = 1;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h10);
    do_reset(1);
    step(); chk("t5_grant_c1", 32'(bus.grant), 32'h4);
    next_cycle();
    en = 4'b1110;
    limit[1] = 1;
    limit[3] = 1;
    sample();
    chk("t5_grant_c2", 32'(bus.grant), 32'h4);
    chk("t5_wr_en_c2", 32'(bus.fifo_wr_en), 32'd0);
    step(); chk("t5_grant_c3", 32'(bus.grant), 32'h0);
    step(); chk("t5_grant_c4", 32'(bus.grant), 32'h8);
    next_cycle();
    en = 4'b1111;
    limit[0] = 1;
    sample();
    chk("t5_grant_c5", 32'(bus.grant), 32'h8);
    step(); chk("t5_grant_c6", 32'(bus.grant), 32'h0);
    step(); chk("t5_grant_c7", 32'(bus.grant), 32'h1);
    step();
    step();
    step(); chk("t5_grant_c10", 32'(bus.grant), 32'h2);
    repeat (4) step();
    chk("t5_grant_end", 32'(bus.grant), 32'h0);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Mid-burst reset on req1's third beat: word dropped, rr_ptr back to 0.
    next_cycle();
    clear_stim();
    en = 4'b0010;
    limit[1] = 3;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h12);
    do_reset(1);
    step(); chk("t6_grant_c1", 32'(bus.grant), 32'h2);
    step();
    next_cycle();
    srst_n = 1'b0;
    en = 4'b0011;
    limit[0] = 1;
    sample();
    chk("t6_wr_en_rst", 32'(bus.fifo_wr_en), 32'd0);
    chk("t6_ready_rst", 32'(bus.req_ready), 32'h0);
    next_cycle();
    srst_n = 1'b1;
    sample();
    chk("t6_grant_after", 32'(bus.grant), 32'h0);
    chk("t6_busy_after", 32'(bus.busy), 32'd0);
    chk("t6_used_no_inc", 32'(bus.fifo_used), 32'd2);
    step(); chk("t6_grant_req0", 32'(bus.grant), 32'h1);
    step();
    step();
    step(); chk("t6_grant_req1", 32'(bus.grant), 32'h2);
    repeat (4) step();
    chk("t6_grant_end", 32'(bus.grant), 32'h0);
    chk("t6_used", 32'(bus.fifo_used), 32'd4);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
